// File: rtl/mio_bus_pkg.sv
// mio_bus_pkg: shared definitions for the memory/IO bus controller.
//   - Address-map constants for the memory-mapped peripherals
//   - FSM state encoding used by mio_bus_ctrl
//   - word_match(): address decode helper that ignores byte-offset bits [1:0]
package mio_bus_pkg;

    localparam logic [31:0] LED_ADDR     = 32'hE000_0000;
    localparam logic [31:0] IN_ADDR      = 32'hF000_0000;
    localparam logic [31:0] TMR_CNT_ADDR = 32'hF000_0004;
    localparam logic [31:0] TMR_CMP_ADDR = 32'hF000_0008;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_WAIT,
        ST_ACK
    } state_t;

    function automatic logic word_match(input logic [31:0] addr, input logic [31:0] base);
        return (addr & 32'hFFFF_FFFC) == base;
    endfunction

endpackage

// File: rtl/mio_bus_if.sv
// mio_bus_if: CPU-side word access handshake.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : driven by the CPU (master), held until cpu_ready
//   cpu_rdata/cpu_ready               : driven by the bus controller (slave)
interface mio_bus_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready
    );

endinterface

// File: rtl/mio_timer.sv
// mio_timer: free-running 32-bit counter with compare interrupt.
// Only compiled when MIO_TIMER_EN is defined.
//   clk, reset : system clock, asynchronous active-high reset
//   cnt_we     : load count from wdata (overrides this cycle's increment)
//   cmp_we     : load compare from wdata, clears irq
//   wdata      : write data
//   count      : current count
//   compare    : current compare value
//   irq        : sticky match flag, cleared by a compare write
`ifdef MIO_TIMER_EN
module mio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_we,
    input  logic        cmp_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        irq
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            compare <= '1;
            irq     <= 1'b0;
        end else begin
            if (cnt_we)
                count <= wdata;
            else
                count <= count + 32'd1;

            if (cmp_we)
                compare <= wdata;

            // A compare write wins over a coincident match; the new
            // compare value only participates from the next cycle.
            if (cmp_we)
                irq <= 1'b0;
            else if (count == compare)
                irq <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: memory/IO bus controller behind the multi-cycle CPU.
// Decodes one CPU word access at a time to block RAM, the LED register,
// the synchronised switch/button inputs and (optionally) a timer.
// Optional feature macro: MIO_TIMER_EN (timer at 0xF000_0004/8, int_out).
// Ports:
//   clk, reset     : system clock, asynchronous active-high reset
//   cpu            : mio_bus_if.slave request/ready handshake
//   ram_addr/we/wdata/rdata : block RAM port, read data RAM_LAT cycles after address
//   sw_in, btn_in  : raw asynchronous switches/buttons
//   led_out        : LED register
//   int_out        : timer interrupt (0 when the timer is not built)
//   bus_err        : sticky unmapped-access flag
module mio_bus_ctrl
    import mio_bus_pkg::*;
#(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mio_bus_if.slave          cpu,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    input  logic [3:0]        btn_in,
    output logic [15:0]       led_out,
    output logic              int_out,
    output logic              bus_err
);

    state_t      state_q, state_n;
    logic [1:0]  lat_cnt;
    logic        lat_done;
    logic [31:0] rdata_q;
    logic [15:0] sw_s1, sw_s2;
    logic [3:0]  btn_s1, btn_s2;

    logic        accept;
    logic        is_ram;
    logic        periph_hit;
    logic [31:0] periph_rdata;
    logic        led_wr;

`ifdef MIO_TIMER_EN
    logic        cnt_wr, cmp_wr;
    logic [31:0] tmr_count, tmr_compare;

    mio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .cnt_we  (accept && cnt_wr),
        .cmp_we  (accept && cmp_wr),
        .wdata   (cpu.cpu_wdata),
        .count   (tmr_count),
        .compare (tmr_compare),
        .irq     (int_out)
    );
`else
    assign int_out = 1'b0;
`endif

    assign accept        = (state_q == ST_IDLE) && cpu.cpu_req;
    assign lat_done      = (lat_cnt == 2'(RAM_LAT - 1));
    assign cpu.cpu_ready = (state_q == ST_ACK);
    assign cpu.cpu_rdata = rdata_q;

    // Address decode on the live bus: the CPU holds addr/we/wdata stable
    // until ready, and everything that depends on them is registered at
    // the accept edge.
    always_comb begin
        is_ram       = (cpu.cpu_addr[31:RAM_AW+2] == '0);
        periph_hit   = 1'b1;
        periph_rdata = '0;
        led_wr       = 1'b0;
`ifdef MIO_TIMER_EN
        cnt_wr       = 1'b0;
        cmp_wr       = 1'b0;
`endif
        if (is_ram) begin
            periph_hit = 1'b1;
        end else if (word_match(cpu.cpu_addr, LED_ADDR)) begin
            periph_rdata = {16'h0000, led_out};
            led_wr       = cpu.cpu_we;
        end else if (word_match(cpu.cpu_addr, IN_ADDR)) begin
            periph_rdata = {12'h000, btn_s2, sw_s2};
`ifdef MIO_TIMER_EN
        end else if (word_match(cpu.cpu_addr, TMR_CNT_ADDR)) begin
            periph_rdata = tmr_count;
            cnt_wr       = cpu.cpu_we;
        end else if (word_match(cpu.cpu_addr, TMR_CMP_ADDR)) begin
            periph_rdata = tmr_compare;
            cmp_wr       = cpu.cpu_we;
`endif
        end else begin
            periph_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:     if (cpu.cpu_req) state_n = is_ram ? ST_RAM_WAIT : ST_ACK;
            ST_RAM_WAIT: if (lat_done) state_n = ST_ACK;
            ST_ACK:      state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
            btn_s1 <= btn_in;
            btn_s2 <= btn_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            lat_cnt   <= '0;
            rdata_q   <= '0;
            led_out   <= '0;
            bus_err   <= 1'b0;
        end else begin
            // ram_we is a single-cycle strobe covering the first RAM_WAIT cycle.
            ram_we <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu.cpu_req) begin
                        if (is_ram) begin
                            ram_addr  <= cpu.cpu_addr[RAM_AW+1:2];
                            ram_wdata <= cpu.cpu_wdata;
                            ram_we    <= cpu.cpu_we;
                            lat_cnt   <= '0;
                        end else begin
                            rdata_q <= cpu.cpu_we ? 32'h0 : periph_rdata;
                            if (led_wr)
                                led_out <= cpu.cpu_wdata[15:0];
                            if (!periph_hit)
                                bus_err <= 1'b1;
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    if (lat_done)
                        rdata_q <= ram_rdata;
                    else
                        lat_cnt <= lat_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: directed self-checking bench for mio_bus_ctrl (RAM_AW=10, RAM_LAT=1)
// with a behavioural RAM attached to the RAM port.
module tb_mio_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] sw_in;
    logic [3:0]  btn_in;
    logic [15:0] led_out;
    logic        int_out;
    logic        bus_err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int         we_pulses = 0;
    logic [9:0] we_addr   = '0;

    logic [31:0] mem [0:1023];

    mio_bus_if bus();

    mio_bus_ctrl #(.RAM_AW(10), .RAM_LAT(1)) dut (
        .clk       (clk),
        .reset     (rst),
        .cpu       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .btn_in    (btn_in),
        .led_out   (led_out),
        .int_out   (int_out),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    always @(negedge clk) begin
        if (ram_we) begin
            we_pulses = we_pulses + 1;
            we_addr   = ram_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access; cycles = edges from request until ready is seen
    // (accept edge counts as 1).
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cycles);
        logic got;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        cycles = 0;
        got    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.cpu_ready) begin
                got = 1'b1;
                break;
            end
        end
        rdata = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
        check("ack_seen", {31'b0, got}, 32'h1);
        @(posedge clk); #1;
        check("ready_one_cycle", {31'b0, bus.cpu_ready}, 32'h0);
    endtask

    logic [31:0] rd;
    int cyc;
    int p0;
    int n;

    initial begin
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        sw_in = '0; btn_in = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_ready",    {31'b0, bus.cpu_ready}, 32'h0);
        check("rst_rdata",    bus.cpu_rdata, 32'h0);
        check("rst_led",      {16'b0, led_out}, 32'h0);
        check("rst_ram_we",   {31'b0, ram_we}, 32'h0);
        check("rst_ram_addr", {22'b0, ram_addr}, 32'h0);
        check("rst_bus_err",  {31'b0, bus_err}, 32'h0);
        check("rst_int",      {31'b0, int_out}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // RAM write then readback
        p0 = we_pulses;
        access(1'b1, 32'h0000_0010, 32'h1234_5678, rd, cyc);
        check("t2_wr_cycles", cyc, 2);
        check("t2_we_pulses", we_pulses - p0, 1);
        check("t2_we_addr", {22'b0, we_addr}, 32'h4);
        p0 = we_pulses;
        access(1'b0, 32'h0000_0010, 32'h0, rd, cyc);
        check("t2_rd_data", rd, 32'h1234_5678);
        check("t2_rd_cycles", cyc, 2);
        check("t2_rd_no_we", we_pulses - p0, 0);

        // Top RAM word; byte offset ignored on readback
        access(1'b1, 32'h0000_0FFC, 32'hA5A5_0001, rd, cyc);
        check("ram_top_addr", {22'b0, we_addr}, 32'h3FF);
        access(1'b0, 32'h0000_0FFE, 32'h0, rd, cyc);
        check("ram_top_data", rd, 32'hA5A5_0001);

        // LED register
        access(1'b1, 32'hE000_0000, 32'hFFFF_ABCD, rd, cyc);
        check("t3_wr_cycles", cyc, 1);
        check("t3_led", {16'b0, led_out}, 32'h0000_ABCD);
        access(1'b0, 32'hE000_0002, 32'h0, rd, cyc);
        check("t3_rd_data", rd, 32'h0000_ABCD);
        check("t3_rd_cycles", cyc, 1);

        // Back-to-back: request held high over 6 edges -> ACK,IDLE,ACK,IDLE,ACK,IDLE
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hE000_0000;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ready) n++;
        end
        bus.cpu_req = 1'b0;
        check("b2b_pulses", n, 3);
        @(posedge clk); #1;
        check("b2b_idle", {31'b0, bus.cpu_ready}, 32'h0);

        // Inputs through synchronisers
        sw_in = 16'h00F0; btn_in = 4'h5;
        repeat (3) @(posedge clk); #1;
        access(1'b0, 32'hF000_0000, 32'h0, rd, cyc);
        check("t4_inputs", rd, 32'h0005_00F0);
        sw_in = 16'h1234; btn_in = 4'hA;
        access(1'b0, 32'hF000_0000, 32'h0, rd, cyc);
        check("sync_delay_old", rd, 32'h0005_00F0);
        access(1'b0, 32'hF000_0000, 32'h0, rd, cyc);
        check("sync_delay_new", rd, 32'h000A_1234);

        // Write to read-only input word is mapped: no error, nothing changes
        access(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, rd, cyc);
        check("ro_wr_no_err", {31'b0, bus_err}, 32'h0);
        check("ro_wr_led", {16'b0, led_out}, 32'h0000_ABCD);

        // Unmapped accesses
        access(1'b0, 32'h0000_1000, 32'h0, rd, cyc);
        check("t5_ram_edge_rd", rd, 32'h0);
        check("t5_ram_edge_cyc", cyc, 1);
        check("t5_bus_err", {31'b0, bus_err}, 32'h1);
        access(1'b0, 32'h8000_0000, 32'h0, rd, cyc);
        check("t5_unmapped_rd", rd, 32'h0);
        access(1'b1, 32'hE000_0004, 32'h0000_1111, rd, cyc);
        check("t5_wr_dropped", {16'b0, led_out}, 32'h0000_ABCD);
`ifndef MIO_TIMER_EN
        access(1'b0, 32'hF000_0004, 32'h0, rd, cyc);
        check("no_tmr_rd", rd, 32'h0);
        check("no_tmr_int", {31'b0, int_out}, 32'h0);
`endif
        access(1'b0, 32'h0000_0010, 32'h0, rd, cyc);
        check("t5_ram_after", rd, 32'h1234_5678);
        check("t5_err_sticky", {31'b0, bus_err}, 32'h1);

`ifdef MIO_TIMER_EN
        access(1'b1, 32'hF000_0008, 32'd20, rd, cyc);
        access(1'b1, 32'hF000_0004, 32'd0, rd, cyc);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (int_out) break;
        end
        check("t6_int_delay", n, 20);
        access(1'b1, 32'hF000_0008, 32'h0000_1000, rd, cyc);
        check("t6_int_clear", {31'b0, int_out}, 32'h0);
        access(1'b0, 32'hF000_0008, 32'h0, rd, cyc);
        check("t6_cmp_rd", rd, 32'h0000_1000);
        access(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, cyc);
        access(1'b0, 32'hF000_0004, 32'h0, rd, cyc);
        check("t6_cnt_max", rd, 32'hFFFF_FFFF);
        access(1'b0, 32'hF000_0004, 32'h0, rd, cyc);
        check("t6_cnt_wrap", rd, 32'h0000_0001);
`endif

        // Reset in the middle of a RAM access
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h0000_0020; bus.cpu_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("t1_in_wait", {31'b0, ram_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("t1_ready",    {31'b0, bus.cpu_ready}, 32'h0);
        check("t1_ram_we",   {31'b0, ram_we}, 32'h0);
        check("t1_led",      {16'b0, led_out}, 32'h0);
        check("t1_bus_err",  {31'b0, bus_err}, 32'h0);
        check("t1_ram_addr", {22'b0, ram_addr}, 32'h0);
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        check("t1_ready_held", {31'b0, bus.cpu_ready}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 32'hE000_0000, 32'h0, rd, cyc);
        check("t1_post_rd", rd, 32'h0);
        check("t1_post_cyc", cyc, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
